tdot_pipe: RTL and testbench
============================

# tdot_pipe

Parametrised, fully pipelined unsigned dot-product engine: computes y = c + Σ a[k]·b[k] over LANES lanes of WIDTH-bit operands, modulo 2^WIDTH. It generalises the fixed three-lane multiply-add chain into a systolic cascade with input skew, so every lane of one vector is summed coherently. It also adds a valid pipeline, a global stall, and an optional running accumulator. It sits in the reticle DSP benchmark set, between the operand sources and the result consumers.

## Interface
- LANES, default 3: number of multiply lanes, ≥1.
- WIDTH, default 8: operand and result width in bits, 1..18.
- clk  in  1  sole clock; all registers update on its rising edge.
- reset  in  1  asynchronous, active-high; clears every register.
- en  in  1  global clock enable; 0 freezes the entire pipeline.
- in_valid  in  1  operands a, b, c (and first) are valid this cycle.
- a  in  LANES*WIDTH  packed lane operands; lane k = a[k*WIDTH +: WIDTH].
- b  in  LANES*WIDTH  packed lane operands, same packing as a.
- c  in  WIDTH  additive seed for the vector.
- first  in  1  starts a new accumulation; present only with TDOT_ACC_EN.
- out_valid  out  1  y carries a new result this cycle.
- y  out  WIDTH  result.

## Operation
- Lane k operands pass through k skew registers, then the A/B register, then the M register (the product), then the P register.
- c travels with lane 0 through the skew, A and M levels.
- Stage 0 computes P0 = M0 + c. Stage k computes Pk = Mk + P(k-1).
- Products and sums are truncated to WIDTH bits (wrap), unsigned.
- A valid bit travels alongside each pipeline level.
- Data registers at a level load only when that level's incoming valid is 1 and en=1. Otherwise they hold.
- y therefore holds the last valid result through bubbles.
- Without the accumulator, y = P(LANES-1) and out_valid = its valid bit.
- en=0: no register changes, including the valid bits. in_valid and operands are ignored that cycle.

## Timing
- Reset values: out_valid=0, y=0, all internal data and valid registers 0. Reset takes effect immediately, independent of clk. In-flight vectors are discarded.
- Latency L = LANES+2 enabled cycles from in_valid sample to out_valid (LANES+3 with TDOT_ACC_EN).
- With en held high, a vector sampled at edge t produces a result at edge t+L.
- Each en=0 cycle adds exactly one cycle of delay.
- Throughput: one vector per enabled cycle. There is no backpressure.
- out_valid is high for exactly one enabled cycle per accepted vector. During a stall, out_valid and y stay frozen at their current value.
- First valid vector after reset release follows the same latency; there is no warm-up.

## Configuration
- TDOT_ACC_EN defined:
  - Adds the port first and one output register R.
  - On a valid result: R ← first ? dot : R + dot, modulo 2^WIDTH. Here first is the value sampled with that vector, delayed alongside it.
  - y = R. out_valid is delayed one cycle.
  - R resets to 0.
  - first=0 on the first vector after reset accumulates onto 0.
- TDOT_ACC_EN undefined:
  - The port first is absent.
  - y = dot directly, with latency LANES+2.

## Test plan
- LANES=3, WIDTH=8, en=1: a=(1,2,3), b=(4,5,6), c=7, single pulse at cycle 0 -> out_valid for one cycle at cycle 5 with y=39. y holds 39 afterwards.
- Back-to-back vectors on cycles 0,1,2: (a=(1,2,3), b=(4,5,6), c=7), then (a=(1,1,1), b=(1,1,1), c=0), then (a=(0,0,0), b=(0,0,0), c=200) -> y = 39, 3, 200 on cycles 5, 6, 7.
- Overflow: a=b=(255,255,255), c=0 -> y=3 (each product 65025 wraps to 1).
- Stall: vector at cycle 0, en=0 during cycles 2–3 -> result at cycle 7. out_valid and y frozen during the stall.
- Reset asserted asynchronously at cycle 3 with a vector in flight -> out_valid=0 and y=0 immediately. No result emerges after release.
- TDOT_ACC_EN: three vectors giving dot=39 with first=1,0,0 -> y = 39, 78, 117 at cycles 6, 7, 8. A fourth vector with first=1 -> y=39.

Source files
------------

// File: rtl/tdot_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tdot_pipe                                                    |
// | Description : Systolic unsigned dot-product y = c + sum(a[k]*b[k]) mod     |
// |               2^WIDTH, with input skew, valid pipeline and global enable.  |
// |               Define TDOT_ACC_EN for the running accumulator and port      |
// |               first.                                                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tdot_pipe #(
    parameter int LANES = 3,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic [WIDTH-1:0]       c,
`ifdef TDOT_ACC_EN
    input  logic                   first,
`endif
    output logic                   out_valid,
    output logic [WIDTH-1:0]       y
);

`ifdef TDOT_ACC_EN
    localparam int NST = LANES + 3;
`else
    localparam int NST = LANES + 2;
`endif

    logic [NST-1:0]         vld_q, vld_d;
    logic [NST-1:0]         lvl_ld;
    logic [WIDTH-1:0]       c_a_q, c_a_d, c_m_q, c_m_d;
    logic [LANES*WIDTH-1:0] p_bus;
    logic [WIDTH-1:0]       dot;

    // Level s registers load only when the valid entering level s is set.
    assign lvl_ld = {NST{en}} & {vld_q[NST-2:0], in_valid};
    assign dot    = p_bus[(LANES-1)*WIDTH +: WIDTH];

    always_comb begin
        vld_d = en ? {vld_q[NST-2:0], in_valid} : vld_q;
        c_a_d = lvl_ld[0] ? c     : c_a_q;
        c_m_d = lvl_ld[1] ? c_a_q : c_m_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            c_a_q <= '0;
            c_m_q <= '0;
        end else begin
            vld_q <= vld_d;
            c_a_q <= c_a_d;
            c_m_q <= c_m_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WIDTH-1:0] a_src, b_src, p_prev;
        logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d, p_q, p_d;

        if (k == 0) begin : g_direct
            assign a_src  = a[WIDTH-1:0];
            assign b_src  = b[WIDTH-1:0];
            assign p_prev = c_m_q;
        end else begin : g_skew
            logic [WIDTH-1:0] sa_q [k];
            logic [WIDTH-1:0] sa_d [k];
            logic [WIDTH-1:0] sb_q [k];
            logic [WIDTH-1:0] sb_d [k];

            always_comb begin
                sa_d[0] = lvl_ld[0] ? a[k*WIDTH +: WIDTH] : sa_q[0];
                sb_d[0] = lvl_ld[0] ? b[k*WIDTH +: WIDTH] : sb_q[0];
                for (int j = 1; j < k; j++) begin
                    sa_d[j] = lvl_ld[j] ? sa_q[j-1] : sa_q[j];
                    sb_d[j] = lvl_ld[j] ? sb_q[j-1] : sb_q[j];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int j = 0; j < k; j++) begin
                        sa_q[j] <= '0;
                        sb_q[j] <= '0;
                    end
                end else begin
                    sa_q <= sa_d;
                    sb_q <= sb_d;
                end
            end

            assign a_src  = sa_q[k-1];
            assign b_src  = sb_q[k-1];
            assign p_prev = p_bus[(k-1)*WIDTH +: WIDTH];
        end

        always_comb begin
            a_d = lvl_ld[k]   ? a_src          : a_q;
            b_d = lvl_ld[k]   ? b_src          : b_q;
            m_d = lvl_ld[k+1] ? a_q * b_q      : m_q;
            p_d = lvl_ld[k+2] ? m_q + p_prev   : p_q;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                a_q <= '0;
                b_q <= '0;
                m_q <= '0;
                p_q <= '0;
            end else begin
                a_q <= a_d;
                b_q <= b_d;
                m_q <= m_d;
                p_q <= p_d;
            end
        end

        assign p_bus[k*WIDTH +: WIDTH] = p_q;
    end

`ifdef TDOT_ACC_EN
    logic [NST-2:0]   fst_q, fst_d;
    logic [WIDTH-1:0] r_q, r_d;

    // first rides alongside its vector up to the last P level.
    always_comb begin
        fst_d[0] = lvl_ld[0] ? first : fst_q[0];
        for (int s = 1; s < NST-1; s++) begin
            fst_d[s] = lvl_ld[s] ? fst_q[s-1] : fst_q[s];
        end
        r_d = lvl_ld[NST-1] ? (fst_q[NST-2] ? dot : r_q + dot) : r_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fst_q <= '0;
            r_q   <= '0;
        end else begin
            fst_q <= fst_d;
            r_q   <= r_d;
        end
    end

    assign y = r_q;
`else
    assign y = dot;
`endif

    assign out_valid = vld_q[NST-1];

endmodule
`default_nettype wire

// File: tb/tb_tdot_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tdot_pipe                                                 |
// | Description : Directed and random stimulus for tdot_pipe, checked against  |
// |               a queue-based arithmetic reference model.                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_tdot_pipe;
    localparam int LANES = 3;
    localparam int WIDTH = 8;
`ifdef TDOT_ACC_EN
    localparam bit ACC = 1'b1;
    localparam int LAT = LANES + 3;
`else
    localparam bit ACC = 1'b0;
    localparam int LAT = LANES + 2;
`endif

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   en = 1'b0;
    logic                   in_valid = 1'b0;
    logic [LANES*WIDTH-1:0] a = '0;
    logic [LANES*WIDTH-1:0] b = '0;
    logic [WIDTH-1:0]       c = '0;
    logic                   first = 1'b0;
    logic                   out_valid;
    logic [WIDTH-1:0]       y;

    tdot_pipe #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .c        (c),
`ifdef TDOT_ACC_EN
        .first    (first),
`endif
        .out_valid(out_valid),
        .y        (y)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [WIDTH-1:0] val;
        bit               f;
    } item_t;

    item_t            pend[$];
    int               ecount = 0;
    logic [WIDTH-1:0] exp_y = '0;
    logic             exp_ov = 1'b0;
    int               total = 0;
    int               bad = 0;

    function automatic logic [WIDTH-1:0] ref_dot(input logic [LANES*WIDTH-1:0] va,
                                                 input logic [LANES*WIDTH-1:0] vb,
                                                 input logic [WIDTH-1:0] vc);
        longint s;
        s = longint'(vc);
        for (int k = 0; k < LANES; k++)
            s += longint'(va[k*WIDTH +: WIDTH]) * longint'(vb[k*WIDTH +: WIDTH]);
        return s[WIDTH-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, check just after.
    task automatic step(input bit e, input bit v, input logic [LANES*WIDTH-1:0] ta,
                        input logic [LANES*WIDTH-1:0] tb_, input logic [WIDTH-1:0] tc,
                        input bit tf, input string tag);
        item_t it;
        en = e; in_valid = v; a = ta; b = tb_; c = tc; first = tf;
        @(posedge clk);
        if (e) begin
            ecount++;
            if (v) pend.push_back('{ecount + LAT - 1, ref_dot(ta, tb_, tc), tf});
            if (pend.size() > 0 && pend[0].due == ecount) begin
                it = pend.pop_front();
                exp_y  = (ACC && !it.f) ? exp_y + it.val : it.val;
                exp_ov = 1'b1;
            end else begin
                exp_ov = 1'b0;
            end
        end
        #1;
        chk({tag, "_ov"}, {31'd0, out_valid}, {31'd0, exp_ov});
        chk({tag, "_y"}, {{(32-WIDTH){1'b0}}, y}, {{(32-WIDTH){1'b0}}, exp_y});
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, '0, 1'b0, tag);
    endtask

    localparam logic [LANES*WIDTH-1:0] A123 = {8'd3, 8'd2, 8'd1};
    localparam logic [LANES*WIDTH-1:0] B456 = {8'd6, 8'd5, 8'd4};
    localparam logic [LANES*WIDTH-1:0] ONES = {8'd1, 8'd1, 8'd1};
    localparam logic [LANES*WIDTH-1:0] FULL = {8'd255, 8'd255, 8'd255};

    initial begin
        // Reset state
        #2;
        chk("reset_ov", {31'd0, out_valid}, 32'd0);
        chk("reset_y", {24'd0, y}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single vector, then hold through bubbles
        step(1'b1, 1'b1, A123, B456, 8'd7, 1'b1, "single");
        idle(LAT + 2, "single_tail");
        chk("single_hold_39", {24'd0, y}, 32'd39);

        // Back-to-back vectors
        step(1'b1, 1'b1, A123, B456, 8'd7, 1'b1, "b2b");
        step(1'b1, 1'b1, ONES, ONES, 8'd0, 1'b1, "b2b");
        step(1'b1, 1'b1, '0, '0, 8'd200, 1'b1, "b2b");
        idle(LAT + 1, "b2b_tail");
        chk("b2b_last_200", {24'd0, y}, 32'd200);

        // Wrap-around of products and sum
        step(1'b1, 1'b1, FULL, FULL, 8'd0, 1'b1, "ovf");
        idle(LAT + 1, "ovf_tail");
        chk("ovf_3", {24'd0, y}, 32'd3);

        // Stall in the middle of a vector's flight, operands presented while stalled
        step(1'b1, 1'b1, A123, ONES, 8'd9, 1'b1, "stall");
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, "stall");
        step(1'b0, 1'b1, FULL, FULL, 8'd1, 1'b1, "stall_off");
        step(1'b0, 1'b1, FULL, FULL, 8'd1, 1'b1, "stall_off");
        idle(LAT + 1, "stall_tail");

        // Stall while the result is on the output
        step(1'b1, 1'b1, B456, B456, 8'd2, 1'b1, "ostall");
        idle(LAT - 1, "ostall");
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, "ostall_off");
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, "ostall_off");
        idle(2, "ostall_tail");

        // Accumulation sequence (each vector's own dot without the accumulator)
        step(1'b1, 1'b1, A123, B456, 8'd7, 1'b1, "acc");
        step(1'b1, 1'b1, A123, B456, 8'd7, 1'b0, "acc");
        step(1'b1, 1'b1, A123, B456, 8'd7, 1'b0, "acc");
        idle(2, "acc");
        step(1'b1, 1'b1, A123, B456, 8'd7, 1'b1, "acc");
        idle(LAT + 1, "acc_tail");
        chk("acc_restart_39", {24'd0, y}, 32'd39);

        // Random traffic with random stalls
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) < 8), $urandom_range(0, 1) == 1,
                 LANES*WIDTH'($urandom), LANES*WIDTH'($urandom), WIDTH'($urandom),
                 $urandom_range(0, 3) == 0, "rand");
        end
        idle(LAT + 1, "rand_tail");

        // Asynchronous reset with vectors in flight
        step(1'b1, 1'b1, A123, B456, 8'd7, 1'b1, "arst");
        step(1'b1, 1'b1, FULL, ONES, 8'd5, 1'b0, "arst");
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, "arst");
        #2;
        reset = 1'b1;
        #1;
        chk("arst_now_ov", {31'd0, out_valid}, 32'd0);
        chk("arst_now_y", {24'd0, y}, 32'd0);
        pend.delete();
        exp_y  = '0;
        exp_ov = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(LAT + 3, "arst_after");

        // First vector after reset, first=0, accumulates onto zero
        step(1'b1, 1'b1, ONES, B456, 8'd1, 1'b0, "post_rst");
        idle(LAT + 1, "post_rst_tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
